// File: rtl/lsu_store_buffer_if.sv
// Memory-controller side of the LSU: registered request bus out, busy/done/read data back.
interface lsu_store_buffer_if #(
  parameter int XLEN = 32
);
  logic            mem_busy_i;
  logic            mem_done_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_req_o;
  logic            mem_wr_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [2:0]      mem_len_o;
  logic [XLEN-1:0] mem_wdata_o;

  modport master (
    input  mem_busy_i, mem_done_i, mem_rdata_i,
    output mem_req_o, mem_wr_o, mem_addr_o, mem_len_o, mem_wdata_o
  );

  modport slave (
    output mem_busy_i, mem_done_i, mem_rdata_i,
    input  mem_req_o, mem_wr_o, mem_addr_o, mem_len_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_store_buffer.sv
// Memory-stage LSU with a posted-write FIFO; loads bypass queued stores unless they hit the same word.
// Request is registered one cycle after the issue decision; stall_o holds loads until done, stores when full, FENCE until drained.
module lsu_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op_i,
  input  logic [REG_W-1:0] wd_i,
  input  logic             wreg_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  addr_i,
  output logic [REG_W-1:0] wd_o,
  output logic             wreg_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic             stall_o,
  output logic             sb_empty_o,
  lsu_store_buffer_if.master mem
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0]  buf_addr [DEPTH];
  logic [XLEN-1:0]  buf_data [DEPTH];
  logic [2:0]       buf_len  [DEPTH];
  logic [PTR_W-1:0] age      [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic            is_load, is_store, is_fence;
  logic [2:0]      op_len;
  logic [XLEN-1:0] st_data, ld_data;
  logic            conflict, push, pop, issue_load, issue_drain;
  logic [XLEN-1:0] head_addr, head_data;
  logic [2:0]      head_len;

  always_comb begin
    is_load  = (op_i >= 4'd1) && (op_i <= 4'd5);
    is_store = (op_i >= 4'd6) && (op_i <= 4'd8);
    is_fence = (op_i == 4'd9);
    case (op_i)
      4'd1, 4'd2, 4'd6: op_len = 3'd1;
      4'd3, 4'd4, 4'd7: op_len = 3'd2;
      default:          op_len = 3'd4;
    endcase
    case (op_len)
      3'd1:    st_data = {{(XLEN-8){1'b0}}, wdata_i[7:0]};
      3'd2:    st_data = {{(XLEN-16){1'b0}}, wdata_i[15:0]};
      default: st_data = wdata_i;
    endcase
    case (op_i)
      4'd1:    ld_data = {{(XLEN-8){mem.mem_rdata_i[7]}}, mem.mem_rdata_i[7:0]};
      4'd2:    ld_data = {{(XLEN-8){1'b0}}, mem.mem_rdata_i[7:0]};
      4'd3:    ld_data = {{(XLEN-16){mem.mem_rdata_i[15]}}, mem.mem_rdata_i[15:0]};
      4'd4:    ld_data = {{(XLEN-16){1'b0}}, mem.mem_rdata_i[15:0]};
      default: ld_data = mem.mem_rdata_i;
    endcase
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = PTR_W'(i) - rd_ptr;
      if (({1'b0, age[i]} < count) && (buf_addr[i][XLEN-1:2] == addr_i[XLEN-1:2]))
        conflict = 1'b1;
    end
    conflict = conflict & is_load;
  end

  // With an empty buffer the incoming store is the head, so it can be issued in the same cycle it is enqueued.
  always_comb begin
    if (count == '0) begin
      head_addr = addr_i;
      head_data = st_data;
      head_len  = op_len;
    end else begin
      head_addr = buf_addr[rd_ptr];
      head_data = buf_data[rd_ptr];
      head_len  = buf_len[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_load  = 1'b0;
    issue_drain = 1'b0;
    stall_o     = 1'b0;
    pop         = (state == DRAIN) && mem.mem_done_i;
    if (is_load)
      stall_o = !((state == LOAD) && mem.mem_done_i);
    else if (is_store)
      stall_o = (count == CNT_W'(DEPTH)) && !pop;
    else if (is_fence)
      stall_o = (count != '0) || (state == DRAIN);
    push = is_store && !stall_o;
    case (state)
      IDLE: begin
        if (!mem.mem_busy_i) begin
          if (is_load && !conflict) begin
            issue_load = 1'b1;
            state_nxt  = LOAD;
          end else if ((count != '0) || push) begin
            issue_drain = 1'b1;
            state_nxt   = DRAIN;
          end
        end
      end
      LOAD:    if (mem.mem_done_i) state_nxt = IDLE;
      DRAIN:   if (mem.mem_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wd_o    = wd_i;
    wreg_o  = wreg_i;
    wdata_o = wdata_i;
    if (is_store || is_fence) begin
      wreg_o  = 1'b0;
      wdata_o = '0;
    end else if (is_load) begin
      wdata_o = ((state == LOAD) && mem.mem_done_i) ? ld_data : '0;
    end
  end

  assign sb_empty_o = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_wr_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_len_o   <= '0;
      mem.mem_wdata_o <= '0;
    end else begin
      mem.mem_req_o <= issue_load | issue_drain;
      if (issue_load) begin
        mem.mem_wr_o    <= 1'b0;
        mem.mem_addr_o  <= addr_i;
        mem.mem_len_o   <= op_len;
        mem.mem_wdata_o <= '0;
      end else if (issue_drain) begin
        mem.mem_wr_o    <= 1'b1;
        mem.mem_addr_o  <= head_addr;
        mem.mem_len_o   <= head_len;
        mem.mem_wdata_o <= head_data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= addr_i;
      buf_data[wr_ptr] <= st_data;
      buf_len[wr_ptr]  <= op_len;
    end
  end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: the bench plays mem_ctrl and upstream pipeline, and a queue model
// of posted stores predicts every request, stall and write-back value.
module tb_lsu_store_buffer;
  localparam int XLEN = 32, DEPTH = 4, REG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       op_i;
  logic [REG_W-1:0] wd_i, wd_o;
  logic             wreg_i, wreg_o, stall_o, sb_empty_o;
  logic [XLEN-1:0]  wdata_i, addr_i, wdata_o;

  lsu_store_buffer_if #(.XLEN(XLEN)) mem_if ();

  lsu_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .addr_i(addr_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_o(stall_o),
    .sb_empty_o(sb_empty_o), .mem(mem_if)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [2:0] len;} st_t;
  typedef struct {logic [3:0] op; logic [31:0] addr; logic [31:0] data; logic [4:0] wd; logic wreg;} op_t;

  st_t  sb_q[$];
  op_t  script[$];
  op_t  cur;
  bit   inflight, inflight_wr, exp_req, exp_wr, post_rst, random_ops, rdata_rand, abort;
  int   lat, lat_min, lat_max, busy_mode, op_age;
  logic [31:0] rdata_fix;

  function automatic logic [2:0] len_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 3'd1;
      4'd3, 4'd4, 4'd7: return 3'd2;
      default:          return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] mask_len(input logic [31:0] d, input logic [2:0] len);
    if (len == 3'd1) return d & 32'h0000_00FF;
    if (len == 3'd2) return d & 32'h0000_FFFF;
    return d;
  endfunction

  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (op)
      4'd1:    return 32'(b);
      4'd2:    return 32'(d[7:0]);
      4'd3:    return 32'(h);
      4'd4:    return 32'(d[15:0]);
      default: return d;
    endcase
  endfunction

  task automatic add_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    script.push_back('{op: op, addr: addr, data: data, wd: 5'd7, wreg: 1'b1});
  endtask

  task automatic next_op();
    logic [2:0] len;
    if (script.size() != 0) begin
      cur = script.pop_front();
    end else if (random_ops) begin
      cur.op   = 4'($urandom_range(0, 10));
      len      = len_of(cur.op);
      cur.addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if (len == 3'd1)      cur.addr += 32'($urandom_range(0, 3));
      else if (len == 3'd2) cur.addr += 32'($urandom_range(0, 1)) * 2;
      cur.data = $urandom;
      cur.wd   = 5'($urandom);
      cur.wreg = 1'($urandom);
    end else begin
      cur = '{op: 4'd0, addr: 32'h0, data: 32'h1234_0000 + 32'(op_age), wd: 5'd1, wreg: 1'b1};
    end
  endtask

  task automatic cycle(input bit do_rst);
    bit done_now, is_ld, is_st, is_fn, conflict, exp_stall, push, req_now;
    @(negedge clk);
    rst     = do_rst;
    op_i    = cur.op;
    addr_i  = cur.addr;
    wdata_i = cur.data;
    wd_i    = cur.wd;
    wreg_i  = cur.wreg;
    done_now = 1'b0;
    req_now  = 1'b0;
    if (!do_rst) begin
      req_now = mem_if.mem_req_o;
      if (post_rst) begin
        check_eq("rst_mem_wr", mem_if.mem_wr_o, 0);
        check_eq("rst_mem_addr", mem_if.mem_addr_o, 0);
        check_eq("rst_mem_len", mem_if.mem_len_o, 0);
        check_eq("rst_mem_wdata", mem_if.mem_wdata_o, 0);
        post_rst = 1'b0;
      end
      check_eq("req_timing", req_now, exp_req);
      if (inflight) begin
        if (lat == 0) done_now = 1'b1;
        else lat--;
      end
      if (req_now) begin
        check_eq("req_kind", mem_if.mem_wr_o, exp_wr);
        if (mem_if.mem_wr_o) begin
          check_eq("wr_q_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            check_eq("wr_addr", mem_if.mem_addr_o, sb_q[0].addr);
            check_eq("wr_data", mem_if.mem_wdata_o, sb_q[0].data);
            check_eq("wr_len", mem_if.mem_len_o, sb_q[0].len);
          end
        end else begin
          check_eq("rd_addr", mem_if.mem_addr_o, cur.addr);
          check_eq("rd_len", mem_if.mem_len_o, len_of(cur.op));
        end
        inflight    = 1'b1;
        inflight_wr = mem_if.mem_wr_o;
        lat         = $urandom_range(lat_min, lat_max);
      end
    end
    mem_if.mem_busy_i  = inflight ? 1'b1 : (busy_mode == 1) ? 1'b1 :
                         (busy_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    mem_if.mem_done_i  = done_now || (!inflight && busy_mode == 2 && $urandom_range(0, 7) == 0);
    mem_if.mem_rdata_i = rdata_rand ? $urandom : rdata_fix;
    #1;
    if (do_rst) begin
      sb_q.delete();
      inflight = 1'b0;
      exp_req  = 1'b0;
      post_rst = 1'b1;
      op_age   = 0;
      next_op();
      return;
    end
    is_ld = cur.op inside {[4'd1:4'd5]};
    is_st = cur.op inside {[4'd6:4'd8]};
    is_fn = (cur.op == 4'd9);
    if (is_ld)      exp_stall = !(done_now && !inflight_wr);
    else if (is_st) exp_stall = (sb_q.size() == DEPTH) && !(done_now && inflight_wr);
    else if (is_fn) exp_stall = (sb_q.size() != 0) || (inflight && inflight_wr);
    else            exp_stall = 1'b0;
    check_eq("stall", stall_o, exp_stall);
    check_eq("sb_empty", sb_empty_o, sb_q.size() == 0);
    check_eq("wd", wd_o, cur.wd);
    if (is_st || is_fn) begin
      check_eq("wreg_mem", wreg_o, 0);
      check_eq("wdata_mem", wdata_o, 0);
    end else begin
      check_eq("wreg", wreg_o, cur.wreg);
      if (!is_ld) check_eq("wdata_nop", wdata_o, cur.data);
      else if (done_now && !inflight_wr) check_eq("load_data", wdata_o, load_result(cur.op, mem_if.mem_rdata_i));
    end
    conflict = 1'b0;
    foreach (sb_q[i]) if (is_ld && sb_q[i].addr[31:2] == cur.addr[31:2]) conflict = 1'b1;
    push = is_st && !exp_stall;
    if (!inflight && !mem_if.mem_busy_i) begin
      exp_req = (is_ld && !conflict) || (sb_q.size() != 0) || push;
      exp_wr  = !(is_ld && !conflict);
    end else begin
      exp_req = 1'b0;
    end
    if (done_now) begin
      if (inflight_wr && sb_q.size() != 0) void'(sb_q.pop_front());
      inflight = 1'b0;
    end
    if (push) sb_q.push_back('{addr: cur.addr, data: mask_len(cur.data, len_of(cur.op)), len: len_of(cur.op)});
    if (exp_stall) begin
      op_age++;
      if (op_age > 100) begin
        check_eq("stall_bound", op_age, 0);
        abort = 1'b1;
      end
    end else begin
      op_age = 0;
      next_op();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n && !abort; i++) cycle(1'b0);
  endtask

  initial begin
    cur = '{op: 4'd0, addr: 32'h0, data: 32'h0, wd: 5'd0, wreg: 1'b0};
    busy_mode = 0; lat_min = 1; lat_max = 1; rdata_fix = 32'h0000_0080;
    rdata_rand = 1'b0; random_ops = 1'b0; abort = 1'b0; op_age = 0;
    inflight = 1'b0; inflight_wr = 1'b0; exp_req = 1'b0; exp_wr = 1'b0; post_rst = 1'b0;
    rst = 1'b1; op_i = '0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; addr_i = '0;
    mem_if.mem_busy_i = 1'b0; mem_if.mem_done_i = 1'b0; mem_if.mem_rdata_i = '0;
    cycle(1'b1);
    cycle(1'b1);

    // Directed: store issue, byte loads, load bypassing queued stores, same-word hazard.
    add_op(4'd8, 32'h100, 32'hDEAD_BEEF);
    add_op(4'd0, 32'h0, 32'h5555_0001);
    add_op(4'd1, 32'h203, 32'h0);
    add_op(4'd2, 32'h203, 32'h0);
    add_op(4'd6, 32'h300, 32'hAABB_CC11);
    add_op(4'd6, 32'h304, 32'hAABB_CC22);
    add_op(4'd6, 32'h308, 32'hAABB_CC33);
    add_op(4'd5, 32'h400, 32'h0);
    add_op(4'd7, 32'h500, 32'h9876_1234);
    add_op(4'd4, 32'h502, 32'h0);
    add_op(4'd3, 32'h203, 32'h0);
    run(50);

    // Full buffer while mem_ctrl is busy, then drain with simultaneous pop/push.
    busy_mode = 1;
    for (int i = 0; i < 5; i++) add_op(4'd8, 32'h700 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i));
    run(10);
    busy_mode = 0;
    run(30);

    // FENCE behind two buffered stores.
    add_op(4'd8, 32'h800, 32'h1111_1111);
    add_op(4'd8, 32'h804, 32'h2222_2222);
    add_op(4'd9, 32'h0, 32'h0);
    run(20);

    // Reset in the middle of a drain.
    add_op(4'd8, 32'h900, 32'h3333_3333);
    add_op(4'd8, 32'h904, 32'h4444_4444);
    for (int i = 0; i < 20 && !(inflight && inflight_wr) && !abort; i++) cycle(1'b0);
    check_eq("drain_before_rst", inflight && inflight_wr, 1);
    cycle(1'b1);
    run(5);

    // Randomized traffic over a small address window to provoke word conflicts.
    random_ops = 1'b1; rdata_rand = 1'b1; busy_mode = 2; lat_min = 0; lat_max = 3;
    run(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
